ipc_matrix_scan: RTL and testbench

IPC_MATRIX_SCAN -- requirements
Module: ipc_matrix_scan

---
 rtl/ipc_matrix_scan.sv | 245 ++++++++++++++++++++++++
 tb/tb_ipc_matrix_scan.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipc_matrix_scan.sv
// Key-matrix scanner: synchronise, debounce, then report make/break events via a FWFT FIFO.
// Optional joystick merging is enabled by defining JOY_MERGE_EN.
module ipc_matrix_scan #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int NJOY       = 2,
    parameter int JOY_BASE   = 8,
    parameter int DEB_CYCLES = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int N         = ROWS * COLS,
    localparam int IW        = $clog2(N)
) (
    input  logic              clk11,
    input  logic              reset_n,
    input  logic [N-1:0]      raw_matrix,
    input  logic [5*NJOY-1:0] js,
    input  logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_data,
    output logic              key_any,
    output logic [IW:0]       evt_data,
    output logic              evt_valid,
    input  logic              evt_rd,
    output logic              evt_full
);

    // FIFO_DEPTH must be a power of two and at least 2.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    // ------------------------------------------------------------------
    // Input synchronisers and merged key vector
    // ------------------------------------------------------------------
    logic [N-1:0] raw_s1_q;
    logic [N-1:0] raw_s2_q;
    logic [N-1:0] merged;

    always_ff @(posedge clk11 or negedge reset_n) begin
        if (!reset_n) begin
            raw_s1_q <= '0;
            raw_s2_q <= '0;
        end else begin
            raw_s1_q <= raw_matrix;
            raw_s2_q <= raw_s1_q;
        end
    end

`ifdef JOY_MERGE_EN
    logic [5*NJOY-1:0] js_s1_q;
    logic [5*NJOY-1:0] js_s2_q;

    always_ff @(posedge clk11 or negedge reset_n) begin
        if (!reset_n) begin
            js_s1_q <= '0;
            js_s2_q <= '0;
        end else begin
            js_s1_q <= js;
            js_s2_q <= js_s1_q;
        end
    end

    always_comb begin
        merged = raw_s2_q;
        for (int n = 0; n < NJOY; n++) begin
            for (int b = 0; b < 5; b++) begin
                merged[JOY_BASE + 5*n + b] = raw_s2_q[JOY_BASE + 5*n + b] | js_s2_q[5*n + b];
            end
        end
    end
`else
    // Joystick inputs are deliberately ignored in this build.
    logic unused_js;
    assign unused_js = ^js;

    always_comb begin
        merged = raw_s2_q;
    end
`endif

    // ------------------------------------------------------------------
    // Debounce tick generator
    // ------------------------------------------------------------------
    logic [CW-1:0] tick_cnt_q;
    logic [CW-1:0] tick_cnt_d;
    logic          tick;

    always_comb begin
        tick       = (tick_cnt_q == CW'(DEB_CYCLES - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk11 or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a bit is accepted only when two successive ticks agree
    // ------------------------------------------------------------------
    logic [N-1:0] prev_q;
    logic [N-1:0] prev_d;
    logic [N-1:0] deb_q;
    logic [N-1:0] deb_d;
    logic [N-1:0] agree;

    always_comb begin
        agree  = ~(merged ^ prev_q);
        prev_d = prev_q;
        deb_d  = deb_q;
        if (tick) begin
            prev_d = merged;
            deb_d  = (deb_q & ~agree) | (merged & agree);
        end
    end

    always_ff @(posedge clk11 or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            deb_q  <= '0;
        end else begin
            prev_q <= prev_d;
            deb_q  <= deb_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO pointers (extra MSB distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [IW:0]   push_data;
    logic [IW:0]   fifo_mem [FIFO_DEPTH];

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // ------------------------------------------------------------------
    // Scanner: compare debounced vs reported state one key per clock
    // ------------------------------------------------------------------
    logic [N-1:0]  rep_q;
    logic [N-1:0]  rep_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] ptr_inc;
    logic          differs;

    always_comb begin
        ptr_inc   = (ptr_q == IW'(N - 1)) ? '0 : ptr_q + 1'b1;
        differs   = (deb_q[ptr_q] != rep_q[ptr_q]);
        // Full is sampled from registered pointers, so a same-cycle pop cannot free a slot.
        push      = differs && !fifo_full;
        push_data = {deb_q[ptr_q], ptr_q};
        rep_d     = rep_q;
        ptr_d     = ptr_q;
        if (push) begin
            rep_d[ptr_q] = deb_q[ptr_q];
            ptr_d        = ptr_inc;
        end else if (!differs) begin
            ptr_d = ptr_inc;
        end
    end

    always_ff @(posedge clk11 or negedge reset_n) begin
        if (!reset_n) begin
            rep_q <= '0;
            ptr_q <= '0;
        end else begin
            rep_q <= rep_d;
            ptr_q <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointer update
    // ------------------------------------------------------------------
    always_comb begin
        pop      = evt_rd && !fifo_empty;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk11 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk11) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign evt_valid = !fifo_empty;
    assign evt_full  = fifo_full;
    assign evt_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];

    // ------------------------------------------------------------------
    // Host-facing column read-back and any-key flag
    // ------------------------------------------------------------------
    logic [COLS-1:0] col_data_q;
    logic [COLS-1:0] col_data_d;
    logic            key_any_q;
    logic            key_any_d;

    always_comb begin
        col_data_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel[r]) begin
                col_data_d = col_data_d | deb_q[r*COLS +: COLS];
            end
        end
        key_any_d = |deb_q;
    end

    always_ff @(posedge clk11 or negedge reset_n) begin
        if (!reset_n) begin
            col_data_q <= '0;
            key_any_q  <= 1'b0;
        end else begin
            col_data_q <= col_data_d;
            key_any_q  <= key_any_d;
        end
    end

    assign col_data = col_data_q;
    assign key_any  = key_any_q;

endmodule

// File: tb/tb_ipc_matrix_scan.sv
// Scoreboard bench for ipc_matrix_scan: stimulus queues expected events, a monitor pops and compares on each read.
module tb_ipc_matrix_scan;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int NJOY = 2;
    localparam int N    = 64;
    localparam int DEB  = 16;

    logic        clk11 = 1'b0;
    logic        reset_n;
    logic [63:0] raw_matrix;
    logic [9:0]  js;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        key_any;
    logic [6:0]  evt_data;
    logic        evt_valid;
    logic        evt_rd;
    logic        evt_full;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] exp_q[$];

    always #5 clk11 = ~clk11;

    ipc_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .NJOY(NJOY), .JOY_BASE(8),
        .DEB_CYCLES(DEB), .FIFO_DEPTH(8)
    ) dut (
        .clk11(clk11), .reset_n(reset_n), .raw_matrix(raw_matrix), .js(js),
        .row_sel(row_sel), .col_data(col_data), .key_any(key_any),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_rd(evt_rd),
        .evt_full(evt_full)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted read is compared against the queue head.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk11);
            if (reset_n === 1'b1 && evt_valid === 1'b1 && evt_rd === 1'b1) begin
                $display("evt %s idx=%0d", evt_data[6] ? "make" : "break", evt_data[5:0]);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %0h, expected none", evt_data);
                end else begin
                    e = exp_q.pop_front();
                    check("event", {57'd0, evt_data}, {57'd0, e});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk11);
        #1;
    endtask

    task automatic drain(input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            cyc(1);
            i++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_full(input int budget);
        int i;
        i = 0;
        while (evt_full !== 1'b1 && i < budget) begin
            cyc(1);
            i++;
        end
    endtask

    // Release happens 1 time unit after a clock edge, so the tick counter and scan
    // pointer both leave 0 on the same edge; keys present at release debounce on the
    // second tick, edge 2*DEB, when the pointer sits at (2*DEB) mod N.
    task automatic do_reset(input logic [63:0] raw_rel, input logic [9:0] js_rel);
        cyc(1);
        reset_n    = 1'b0;
        evt_rd     = 1'b0;
        raw_matrix = '0;
        js         = '0;
        exp_q.delete();
        cyc(3);
        raw_matrix = raw_rel;
        js         = js_rel;
        reset_n    = 1'b1;
    endtask

    initial begin
        logic [63:0] m;
        logic [6:0]  ev;
        int          start;

        reset_n    = 1'b1;
        raw_matrix = '0;
        js         = '0;
        row_sel    = 8'hFF;
        evt_rd     = 1'b0;
        #2;

        // ---- Reset with all keys held ----
        reset_n    = 1'b0;
        raw_matrix = '1;
        cyc(4);
        check("rst_col_data", 64'(col_data), 64'd0);
        check("rst_key_any", 64'(key_any), 64'd0);
        check("rst_evt_valid", 64'(evt_valid), 64'd0);
        check("rst_evt_full", 64'(evt_full), 64'd0);
        check("rst_evt_data", 64'(evt_data), 64'd0);
        reset_n = 1'b1;
        start = (2 * DEB) % N;
        for (int i = 0; i < N; i++) begin
            ev = {1'b1, 6'((start + i) % N)};
            exp_q.push_back(ev);
        end
        wait_full(200);
        check("rst_fill_full", 64'(evt_full), 64'd1);
        check("rst_fill_head", 64'(evt_data), {57'd0, 1'b1, 6'(start)});
        evt_rd = 1'b1;
        drain(400, "rst_drain");
        cyc(2);
        check("rst_key_any_set", 64'(key_any), 64'd1);
        check("rst_col_all", 64'(col_data), 64'hFF);

        // ---- Single press of key 10 ----
        row_sel = 8'h00;
        do_reset(64'h400, 10'd0);
        evt_rd = 1'b1;
        exp_q.push_back(7'b1_001010);
        drain(2*DEB + 64 + 4, "press_latency");
        row_sel = 8'h02;
        cyc(1);
        check("press_col_row1", 64'(col_data), 64'h04);
        check("press_key_any", 64'(key_any), 64'd1);
        row_sel = 8'h00;
        cyc(1);
        check("press_col_none", 64'(col_data), 64'h00);
        row_sel = 8'h01;
        cyc(1);
        check("press_col_row0", 64'(col_data), 64'h00);
        row_sel = 8'h03;
        cyc(1);
        check("press_col_multi", 64'(col_data), 64'h04);
        raw_matrix = '0;
        exp_q.push_back(7'b0_001010);
        drain(2*DEB + 64 + 4, "release_latency");
        cyc(2);
        check("release_key_any", 64'(key_any), 64'd0);

        // ---- Glitches: 1 clock and DEB-1 clocks ----
        raw_matrix[10] = 1'b1;
        cyc(1);
        raw_matrix[10] = 1'b0;
        cyc(120);
        check("glitch1_valid", 64'(evt_valid), 64'd0);
        check("glitch1_key_any", 64'(key_any), 64'd0);
        raw_matrix[10] = 1'b1;
        cyc(DEB - 1);
        raw_matrix[10] = 1'b0;
        cyc(120);
        check("glitch15_valid", 64'(evt_valid), 64'd0);
        check("glitch15_key_any", 64'(key_any), 64'd0);

        // ---- Overflow: keys 40..51 with reads withheld ----
        m = 64'hFFF;
        m = m << 40;
        do_reset(m, 10'd0);
        wait_full(200);
        check("ovf_full", 64'(evt_full), 64'd1);
        cyc(20);
        check("ovf_still_full", 64'(evt_full), 64'd1);
        check("ovf_head", 64'(evt_data), {57'd0, 7'b1_101000});
        for (int i = 40; i < 52; i++) begin
            ev = {1'b1, 6'(i)};
            exp_q.push_back(ev);
        end
        evt_rd = 1'b1;
        drain(100, "ovf_drain");
        cyc(2);
        check("ovf_empty", 64'(evt_valid), 64'd0);
        check("ovf_not_full", 64'(evt_full), 64'd0);

        // ---- Joystick channel 0 bit 0 -> key 8 ----
        do_reset(64'd0, 10'd1);
        evt_rd = 1'b1;
`ifdef JOY_MERGE_EN
        exp_q.push_back(7'b1_001000);
`endif
        cyc(120);
        check("joy_queue", 64'(exp_q.size()), 64'd0);
        check("joy_valid", 64'(evt_valid), 64'd0);
`ifdef JOY_MERGE_EN
        check("joy_key_any", 64'(key_any), 64'd1);
`else
        check("joy_key_any", 64'(key_any), 64'd0);
`endif

        // ---- Reset while events are queued ----
        row_sel = 8'hFF;
        m = 64'h7;
        m = m << 40;
        do_reset(m, 10'd0);
        cyc(100);
        check("mid_valid_before", 64'(evt_valid), 64'd1);
        check("mid_head_before", 64'(evt_data), {57'd0, 7'b1_101000});
        check("mid_key_any_before", 64'(key_any), 64'd1);
        @(negedge clk11);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_valid_async", 64'(evt_valid), 64'd0);
        check("mid_data_async", 64'(evt_data), 64'd0);
        check("mid_full_async", 64'(evt_full), 64'd0);
        check("mid_key_any_async", 64'(key_any), 64'd0);
        check("mid_col_async", 64'(col_data), 64'd0);
        exp_q.delete();
        raw_matrix = '0;
        cyc(2);
        reset_n = 1'b1;
        evt_rd  = 1'b1;
        cyc(120);
        check("mid_no_events", 64'(evt_valid), 64'd0);
        check("mid_deb_clear", 64'(key_any), 64'd0);
        check("mid_col_clear", 64'(col_data), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
